// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with redirect priority, stall hold buffer and misaligned-target trap
//
// Ports:
//   clk, reset                       clock; asynchronous active-high reset
//   stall_i                          hazard unit asks IF/ID to hold its instruction
//   branch_taken_i/branch_target_i   EX-stage taken branch and its destination
//   jump_i/jump_target_i             ID-stage j/jal and its destination
//   jr_i/jr_target_i                 ID-stage jr/jalr and its register-sourced destination
//   exception_i                      pipeline exception, redirects to EXC_PC
//   imem_addr_o/imem_req_o           instruction memory address (always pc) and request
//   imem_rdata_i/imem_ready_i        same-cycle instruction memory response
//   pcp4_o/ins_o                     PC+4 and instruction delivered to IF/ID
//   stay_o/null_o                    IF/ID hold and IF/ID flush (bubble)
//   exc_fetch_o/badaddr_o            one-cycle misaligned-target pulse and captured target

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        exception_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] pcp4_o,
  output logic [31:0] ins_o,
  output logic        stay_o,
  output logic        null_o,
  output logic        exc_fetch_o,
  output logic [31:0] badaddr_o
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] hbuf_ins, hbuf_ins_nxt;
  logic [31:0] hbuf_pcp4, hbuf_pcp4_nxt;
  logic        exc_fetch_nxt;
  logic [31:0] badaddr_nxt;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        misaligned;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 by truncation.
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr_o = pc;

  // Redirect source selection, highest priority first.
  always_comb begin
    redirect        = 1'b1;
    redirect_target = 32'h0;
    if (exception_i) begin
      redirect_target = EXC_PC;
    end else if (branch_taken_i) begin
      redirect_target = branch_target_i;
    end else if (jr_i) begin
      redirect_target = jr_target_i;
    end else if (jump_i) begin
      redirect_target = jump_target_i;
    end else begin
      redirect = 1'b0;
    end
  end

  // The exception vector itself is trusted; only control-flow targets are checked.
  assign misaligned = redirect && !exception_i && (redirect_target[1:0] != 2'b00);

  // Next-state and output logic.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    hbuf_ins_nxt  = hbuf_ins;
    hbuf_pcp4_nxt = hbuf_pcp4;
    exc_fetch_nxt = 1'b0;
    badaddr_nxt   = badaddr_o;
    imem_req_o    = (state == FETCH);
    stay_o        = 1'b0;
    null_o        = 1'b0;
    ins_o         = 32'h0;
    pcp4_o        = 32'h0;

    if (redirect) begin
      // Redirect wins over stall: the wrong-path slot becomes a bubble and
      // any held instruction is thrown away.
      null_o        = 1'b1;
      state_nxt     = FETCH;
      hbuf_ins_nxt  = 32'h0;
      hbuf_pcp4_nxt = 32'h0;
      if (misaligned) begin
        pc_nxt        = EXC_PC;
        exc_fetch_nxt = 1'b1;
        badaddr_nxt   = redirect_target;
      end else begin
        pc_nxt = redirect_target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready_i) begin
            if (stall_i) begin
              // Memory answered but ID cannot accept: park the word so the
              // memory is not re-read while the stall lasts.
              stay_o        = 1'b1;
              hbuf_ins_nxt  = imem_rdata_i;
              hbuf_pcp4_nxt = pc_plus4;
              state_nxt     = HOLD;
            end else begin
              ins_o  = imem_rdata_i;
              pcp4_o = pc_plus4;
              pc_nxt = pc_plus4;
            end
          end else if (stall_i) begin
            stay_o = 1'b1;
          end else begin
            null_o = 1'b1;
          end
        end
        HOLD: begin
          if (stall_i) begin
            stay_o = 1'b1;
          end else begin
            ins_o     = hbuf_ins;
            pcp4_o    = hbuf_pcp4;
            pc_nxt    = pc_plus4;
            state_nxt = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end

    // While in reset the stage presents a bubble and makes no request.
    if (reset) begin
      imem_req_o = 1'b0;
      stay_o     = 1'b0;
      null_o     = 1'b1;
      ins_o      = 32'h0;
      pcp4_o     = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hbuf_ins    <= 32'h0;
      hbuf_pcp4   <= 32'h0;
      exc_fetch_o <= 1'b0;
      badaddr_o   <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      hbuf_ins    <= hbuf_ins_nxt;
      hbuf_pcp4   <= hbuf_pcp4_nxt;
      exc_fetch_o <= exc_fetch_nxt;
      badaddr_o   <= badaddr_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h8000_0004;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        exception_i;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ready_i;
  logic [31:0] pcp4_o;
  logic [31:0] ins_o;
  logic        stay_o;
  logic        null_o;
  logic        exc_fetch_o;
  logic [31:0] badaddr_o;

  int tests_run;
  int tests_failed;

  if_fetch_stage #(.RESET_PC(RST_PC), .EXC_PC(EXC_PC)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i), .exception_i(exception_i),
    .imem_addr_o(imem_addr_o), .imem_req_o(imem_req_o),
    .imem_rdata_i(imem_rdata_i), .imem_ready_i(imem_ready_i),
    .pcp4_o(pcp4_o), .ins_o(ins_o), .stay_o(stay_o), .null_o(null_o),
    .exc_fetch_o(exc_fetch_o), .badaddr_o(badaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: answers the presented address in the same cycle.
  assign imem_rdata_i = imem_ready_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken_i = 0; jump_i = 0; jr_i = 0; exception_i = 0;
    branch_target_i = 0; jump_target_i = 0; jr_target_i = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall_i = 0; imem_ready_i = 1; clear_redirects();
    #2;
    tests_run++; if (imem_addr_o !== RST_PC) begin tests_failed++; $display("FAIL rst_addr got %h want %h", imem_addr_o, RST_PC); end
    tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    tests_run++; if ({null_o, stay_o} !== 2'b10) begin tests_failed++; $display("FAIL rst_null_stay got %b want 10", {null_o, stay_o}); end
    tests_run++; if ({ins_o, pcp4_o} !== 64'h0) begin tests_failed++; $display("FAIL rst_ins_pcp4 got %h want 0", {ins_o, pcp4_o}); end
    tests_run++; if ({exc_fetch_o, badaddr_o} !== 33'h0) begin tests_failed++; $display("FAIL rst_exc got %h want 0", {exc_fetch_o, badaddr_o}); end
    tick();
    reset = 0;
  endtask

  // Leaves the stage presenting pc=0x8 with stall still low.
  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      #2;
      tests_run++; if (imem_addr_o !== 32'(4 * i)) begin tests_failed++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr_o, 32'(4 * i)); end
      tests_run++; if (pcp4_o !== 32'(4 * i + 4)) begin tests_failed++; $display("FAIL seq_pcp4%0d got %h want %h", i, pcp4_o, 32'(4 * i + 4)); end
      tests_run++; if (ins_o !== mem_word(32'(4 * i))) begin tests_failed++; $display("FAIL seq_ins%0d got %h want %h", i, ins_o, mem_word(32'(4 * i))); end
      tests_run++; if ({null_o, stay_o, imem_req_o} !== 3'b001) begin tests_failed++; $display("FAIL seq_ctl%0d got %b want 001", i, {null_o, stay_o, imem_req_o}); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stall_hold();
    stall_i = 1;
    #1;
    tests_run++; if ({stay_o, null_o, imem_req_o} !== 3'b101) begin tests_failed++; $display("FAIL hold_first got %b want 101", {stay_o, null_o, imem_req_o}); end
    tick();
    imem_ready_i = 0;
    #2;
    tests_run++; if ({stay_o, null_o, imem_req_o} !== 3'b100) begin tests_failed++; $display("FAIL hold_second got %b want 100", {stay_o, null_o, imem_req_o}); end
    tests_run++; if (imem_addr_o !== 32'h8) begin tests_failed++; $display("FAIL hold_addr got %h want 8", imem_addr_o); end
    tick();
    stall_i = 0;
    #2;
    tests_run++; if (ins_o !== mem_word(32'h8)) begin tests_failed++; $display("FAIL hold_ins got %h want %h", ins_o, mem_word(32'h8)); end
    tests_run++; if (pcp4_o !== 32'hC) begin tests_failed++; $display("FAIL hold_pcp4 got %h want c", pcp4_o); end
    tests_run++; if ({stay_o, null_o} !== 2'b00) begin tests_failed++; $display("FAIL hold_release got %b want 00", {stay_o, null_o}); end
    tick();
    imem_ready_i = 1;
    #2;
    tests_run++; if ({imem_addr_o, imem_req_o} !== {32'hC, 1'b1}) begin tests_failed++; $display("FAIL hold_next got %h want 19", {imem_addr_o, imem_req_o}); end
    tick();
  endtask

  task automatic test_not_ready();
    imem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests_run++; if ({null_o, stay_o} !== 2'b10) begin tests_failed++; $display("FAIL nrdy_ctl%0d got %b want 10", i, {null_o, stay_o}); end
      tests_run++; if (imem_addr_o !== 32'h10) begin tests_failed++; $display("FAIL nrdy_addr%0d got %h want 10", i, imem_addr_o); end
      tests_run++; if ({ins_o, pcp4_o} !== 64'h0) begin tests_failed++; $display("FAIL nrdy_zero%0d got %h want 0", i, {ins_o, pcp4_o}); end
      tick();
    end
    imem_ready_i = 1;
    #2;
    tests_run++; if ({null_o, imem_addr_o} !== 33'h10) begin tests_failed++; $display("FAIL nrdy_resume got %h want 10", {null_o, imem_addr_o}); end
    tick();
  endtask

  task automatic test_redirect_priority();
    stall_i = 1; branch_taken_i = 1; branch_target_i = 32'h100; jump_i = 1; jump_target_i = 32'h200;
    #2;
    tests_run++; if ({null_o, stay_o} !== 2'b10) begin tests_failed++; $display("FAIL br_ctl got %b want 10", {null_o, stay_o}); end
    tests_run++; if ({ins_o, pcp4_o} !== 64'h0) begin tests_failed++; $display("FAIL br_zero got %h want 0", {ins_o, pcp4_o}); end
    tick();
    clear_redirects(); stall_i = 0;
    #2;
    tests_run++; if (imem_addr_o !== 32'h100) begin tests_failed++; $display("FAIL br_target got %h want 100", imem_addr_o); end
    tests_run++; if (exc_fetch_o !== 1'b0) begin tests_failed++; $display("FAIL br_noexc got %b want 0", exc_fetch_o); end
    exception_i = 1; branch_taken_i = 1; branch_target_i = 32'h100;
    tick();
    clear_redirects();
    #2;
    tests_run++; if (imem_addr_o !== EXC_PC) begin tests_failed++; $display("FAIL exc_target got %h want %h", imem_addr_o, EXC_PC); end
    jr_i = 1; jr_target_i = 32'h300; jump_i = 1; jump_target_i = 32'h200;
    tick();
    clear_redirects();
    #2;
    tests_run++; if (imem_addr_o !== 32'h300) begin tests_failed++; $display("FAIL jr_over_j got %h want 300", imem_addr_o); end
  endtask

  task automatic test_misaligned();
    jr_i = 1; jr_target_i = 32'h102;
    tick();
    clear_redirects();
    #2;
    tests_run++; if (imem_addr_o !== EXC_PC) begin tests_failed++; $display("FAIL mis_pc got %h want %h", imem_addr_o, EXC_PC); end
    tests_run++; if (exc_fetch_o !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse got %b want 1", exc_fetch_o); end
    tests_run++; if (badaddr_o !== 32'h102) begin tests_failed++; $display("FAIL mis_badaddr got %h want 102", badaddr_o); end
    tick();
    #2;
    tests_run++; if (exc_fetch_o !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse_end got %b want 0", exc_fetch_o); end
    tests_run++; if (badaddr_o !== 32'h102) begin tests_failed++; $display("FAIL mis_badaddr_hold got %h want 102", badaddr_o); end
  endtask

  task automatic test_wrap();
    jump_i = 1; jump_target_i = 32'hFFFF_FFFC;
    tick();
    clear_redirects();
    #2;
    tests_run++; if (imem_addr_o !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr_o); end
    tests_run++; if (pcp4_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_pcp4 got %h want 0", pcp4_o); end
    tick();
    #2;
    tests_run++; if (imem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_next got %h want 0", imem_addr_o); end
  endtask

  task automatic test_reset_in_hold();
    jump_i = 1; jump_target_i = 32'h40;
    tick();
    clear_redirects(); stall_i = 1;
    tick();
    #1;
    reset = 1;
    #1;
    tests_run++; if ({imem_addr_o, imem_req_o, null_o, stay_o} !== {RST_PC, 3'b010}) begin tests_failed++; $display("FAIL arst_out got %h want %h", {imem_addr_o, imem_req_o, null_o, stay_o}, {RST_PC, 3'b010}); end
    tests_run++; if (badaddr_o !== 32'h0) begin tests_failed++; $display("FAIL arst_badaddr got %h want 0", badaddr_o); end
    tick();
    reset = 0; stall_i = 0;
    #2;
    tests_run++; if ({imem_req_o, ins_o, pcp4_o} !== {1'b1, mem_word(RST_PC), RST_PC + 32'd4}) begin tests_failed++; $display("FAIL arst_refetch got %h want %h", {imem_req_o, ins_o, pcp4_o}, {1'b1, mem_word(RST_PC), RST_PC + 32'd4}); end
  endtask

  // Randomized run against a behavioural model of the fetch stage.
  task automatic test_random();
    logic [31:0] m_pc, m_hins, m_hp4, m_bad, tgt;
    logic        m_held, m_exc, redir;
    logic [31:0] e_ins, e_p4;
    logic        e_null, e_stay;
    int          errs;
    errs = 0;
    reset = 1; tick(); reset = 0;
    m_pc = RST_PC; m_held = 0; m_hins = 0; m_hp4 = 0; m_exc = 0; m_bad = 0;
    for (int n = 0; n < 3000; n++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      imem_ready_i = ($urandom_range(0, 4) != 0);
      exception_i = ($urandom_range(0, 30) == 0);
      branch_taken_i = ($urandom_range(0, 10) == 0);
      jr_i = ($urandom_range(0, 12) == 0);
      jump_i = ($urandom_range(0, 10) == 0);
      branch_target_i = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jr_target_i = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jump_target_i = $urandom & 32'hFFFF_FFFC;
      redir = exception_i | branch_taken_i | jr_i | jump_i;
      tgt = exception_i ? EXC_PC : branch_taken_i ? branch_target_i : jr_i ? jr_target_i : jump_target_i;
      e_null = 0; e_stay = 0; e_ins = 0; e_p4 = 0;
      if (redir) e_null = 1;
      else if (stall_i && (m_held || imem_ready_i)) e_stay = 1;
      else if (m_held) begin e_ins = m_hins; e_p4 = m_hp4; end
      else if (imem_ready_i) begin e_ins = mem_word(m_pc); e_p4 = m_pc + 32'd4; end
      else if (stall_i) e_stay = 1;
      else e_null = 1;
      #2;
      tests_run++; if ({imem_addr_o, imem_req_o} !== {m_pc, !m_held}) begin errs++; tests_failed++; if (errs < 10) $display("FAIL rnd_addr_req cyc %0d got %h want %h", n, {imem_addr_o, imem_req_o}, {m_pc, !m_held}); end
      tests_run++; if ({null_o, stay_o} !== {e_null, e_stay}) begin errs++; tests_failed++; if (errs < 10) $display("FAIL rnd_null_stay cyc %0d got %b want %b", n, {null_o, stay_o}, {e_null, e_stay}); end
      tests_run++; if ({ins_o, pcp4_o} !== {e_ins, e_p4}) begin errs++; tests_failed++; if (errs < 10) $display("FAIL rnd_ins_pcp4 cyc %0d got %h want %h", n, {ins_o, pcp4_o}, {e_ins, e_p4}); end
      tests_run++; if ({exc_fetch_o, badaddr_o} !== {m_exc, m_bad}) begin errs++; tests_failed++; if (errs < 10) $display("FAIL rnd_exc cyc %0d got %h want %h", n, {exc_fetch_o, badaddr_o}, {m_exc, m_bad}); end
      m_exc = 0;
      if (redir) begin
        m_held = 0;
        if (!exception_i && tgt[1:0] != 2'b00) begin m_pc = EXC_PC; m_exc = 1; m_bad = tgt; end
        else m_pc = tgt;
      end else if (m_held) begin
        if (!stall_i) begin m_held = 0; m_pc = m_pc + 32'd4; end
      end else if (imem_ready_i) begin
        if (stall_i) begin m_held = 1; m_hins = mem_word(m_pc); m_hp4 = m_pc + 32'd4; end
        else m_pc = m_pc + 32'd4;
      end
      tick();
    end
    clear_redirects(); stall_i = 0; imem_ready_i = 1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_not_ready();
    test_redirect_priority();
    test_misaligned();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC loaded on reset.
REQ-002 Parameter EXC_PC, default 32'h8000_0004, meaning: exception / misaligned-fetch vector.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 stall_i  input  1  hazard-unit stall: ID instruction must be held.
REQ-006 branch_taken_i  input  1  EX-stage branch resolved taken.
REQ-007 branch_target_i  input  32  branch destination.
REQ-008 jump_i  input  1  ID-stage j/jal.
REQ-009 jump_target_i  input  32  jump destination.
REQ-010 jr_i  input  1  ID-stage jr/jalr.
REQ-011 jr_target_i  input  32  register-sourced destination.
REQ-012 exception_i  input  1  pipeline exception request.
REQ-013 imem_addr_o  output  32  instruction memory address, always equals pc.
REQ-014 imem_req_o  output  1  fetch request.
REQ-015 imem_rdata_i  input  32  instruction word, valid when imem_ready_i=1 in the same cycle.
REQ-016 imem_ready_i  input  1  same-cycle response for the presented address.
REQ-017 pcp4_o  output  32  PC+4 of the delivered instruction, to IF/ID register.
REQ-018 ins_o  output  32  delivered instruction, to IF/ID register.
REQ-019 stay_o  output  1  IF/ID hold.
REQ-020 null_o  output  1  IF/ID flush (insert bubble).
REQ-021 exc_fetch_o  output  1  one-cycle pulse: misaligned redirect target detected.
REQ-022 badaddr_o  output  32  offending target, captured on exc_fetch_o, held until next capture.

Function
REQ-023 Internal state: pc[31:0], hold buffer hbuf_ins/hbuf_pcp4[31:0], FSM {FETCH, HOLD}.
REQ-024 Redirect priority, highest first: exception_i, branch_taken_i, jr_i, jump_i; selected target = EXC_PC, branch_target_i, jr_target_i, jump_target_i respectively.
REQ-025 Selected non-exception target with bits[1:0]!=0: pc <= EXC_PC, exc_fetch_o=1 next cycle only, badaddr_o <= target.
REQ-026 Any redirect cycle: null_o=1, stay_o=0 (redirect overrides stall_i), pc <= target, FSM <= FETCH, hold buffer discarded.
REQ-027 FETCH: imem_req_o=1; imem_addr_o=pc.
REQ-028 FETCH, no redirect, imem_ready_i=1, stall_i=0: ins_o=imem_rdata_i, pcp4_o=pc+4, stay_o=0, null_o=0, pc <= pc+4.
REQ-029 FETCH, no redirect, imem_ready_i=1, stall_i=1: stay_o=1, null_o=0, hbuf <= {imem_rdata_i, pc+4}, pc unchanged, FSM <= HOLD.
REQ-030 FETCH, no redirect, imem_ready_i=0: stall_i=1 -> stay_o=1, null_o=0; stall_i=0 -> null_o=1, stay_o=0; pc unchanged.
REQ-031 HOLD: imem_req_o=0; stall_i=1 -> stay_o=1, stay in HOLD; stall_i=0 -> ins_o=hbuf_ins, pcp4_o=hbuf_pcp4, stay_o=0, null_o=0, pc <= pc+4, FSM <= FETCH.
REQ-032 stay_o and null_o SHALL never both be 1.
REQ-033 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-034 ins_o/pcp4_o SHALL be 0 whenever null_o=1.

Reset
REQ-035 reset=1: pc=RESET_PC, FSM=FETCH, hbuf=0, exc_fetch_o=0, badaddr_o=0 immediately, independent of clk.
REQ-036 During reset: imem_req_o=0, null_o=1, stay_o=0; first fetch of RESET_PC on first edge after release.
REQ-037 Reset asserted in HOLD SHALL discard the buffered instruction.

Verification
REQ-038 Release reset, ready=1, stall=0 -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; pcp4_o 0x4,0x8,0xC; null_o=0.
REQ-039 Stall 2 cycles with ready=1 at pc=0x8 -> stay_o=1 two cycles, imem_req_o=0 in HOLD; on release ins_o=word@0x8, pcp4_o=0xC, next addr 0xC.
REQ-040 ready=0 for 3 cycles at pc=0x10, stall=0 -> null_o=1 three cycles, imem_addr_o stays 0x10.
REQ-041 branch_taken_i (0x100) with jump_i (0x200) and stall_i=1 -> null_o=1, stay_o=0, next imem_addr_o=0x100.
REQ-042 exception_i with branch_taken_i (0x100) -> next pc 0x8000_0004.
REQ-043 jr_i target 0x102 -> next pc 0x8000_0004, exc_fetch_o high exactly one cycle, badaddr_o=0x102.
